// File: rtl/fir_decim_fifo.sv
// Decimating FIFO that sits after the moving-average FIR. It drops the warm-up samples,
// keeps one sample in DECIM, and buffers the kept samples in a first-word-fall-through FIFO.
module fir_decim_fifo #(
  parameter int DATA_W = 16,
  parameter int DECIM  = 8,
  parameter int WARMUP = 9,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_en,
  input  logic signed [DATA_W-1:0]   din,
  output logic signed [DATA_W-1:0]   dout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // 8-bit counters cover the full WARMUP (0..255) and DECIM (1..256) ranges.
  logic [7:0]              wcnt_q, wcnt_d;
  logic [7:0]              phase_q, phase_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic                    ovf_q, ovf_d;
  logic signed [DATA_W-1:0] mem_q [DEPTH];

  logic warm_done, phase_last, push, pop, full, push_ok, drop;

  assign warm_done  = (wcnt_q == 8'(WARMUP));
  assign phase_last = (phase_q == 8'(DECIM - 1));
  assign push       = in_en && warm_done && phase_last;
  assign out_valid  = (level_q != '0);
  assign pop        = out_valid && out_ready;
  assign full       = (level_q == LW'(DEPTH));
  assign push_ok    = push && (!full || pop);
  assign drop       = push && full && !pop;

  always_comb begin
    wcnt_d   = wcnt_q;
    phase_d  = phase_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    if (in_en && !warm_done) wcnt_d = wcnt_q + 8'(1);

    // The phase wraps even when the push is dropped, so decimation alignment is kept.
    if (in_en && warm_done) phase_d = phase_last ? 8'(0) : phase_q + 8'(1);

    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);

    if (push_ok && !pop)      level_d = level_q + LW'(1);
    else if (!push_ok && pop) level_d = level_q - LW'(1);

    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q   <= '0;
      phase_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wcnt_q   <= wcnt_d;
      phase_q  <= phase_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  // The head is masked while empty, so dout reads 0 after reset without clearing the array.
  assign dout     = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Directed bench for fir_decim_fifo: one instance uses the default parameters, and a second
// uses DECIM=4, WARMUP=0 to exercise gapped input.
module tb_fir_decim_fifo;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_en, out_ready, ovf_clr;
  logic signed [15:0] din;
  logic signed [15:0] dout;
  logic               out_valid, overflow;
  logic [3:0]         level;

  logic               in_en2, out_ready2, ovf_clr2;
  logic signed [15:0] din2;
  logic signed [15:0] dout2;
  logic               out_valid2, overflow2;
  logic [3:0]         level2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fir_decim_fifo u_dut (
    .clk(clk), .rst_n(rst_n), .in_en(in_en), .din(din), .dout(dout),
    .out_valid(out_valid), .out_ready(out_ready), .level(level),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  fir_decim_fifo #(.DATA_W(16), .DECIM(4), .WARMUP(0), .DEPTH(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_en(in_en2), .din(din2), .dout(dout2),
    .out_valid(out_valid2), .out_ready(out_ready2), .level(level2),
    .overflow(overflow2), .ovf_clr(ovf_clr2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_en = 0; out_ready = 0; ovf_clr = 0; din = '0;
    in_en2 = 0; out_ready2 = 0; ovf_clr2 = 0; din2 = '0;
    tick(); tick();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid); else n_pass++;
    n_chk++; if (dout !== 16'sd0) $display("FAIL reset_dout got %0d want 0", dout); else n_pass++;
    n_chk++; if (level !== 4'd0) $display("FAIL reset_level got %0d want 0", level); else n_pass++;
    n_chk++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %0b want 0", overflow); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic exp_v;
    test_reset();
    out_ready = 1; in_en = 1;
    for (int k = 1; k <= 41; k++) begin
      din = 16'(k);
      tick();
      exp_v = (k >= 17) && (((k - 17) % 8) == 0);
      n_chk++;
      if (out_valid !== exp_v) $display("FAIL stream_valid k=%0d got %0b want %0b", k, out_valid, exp_v);
      else n_pass++;
      if (exp_v) begin
        n_chk++;
        if (dout !== 16'(k)) $display("FAIL stream_dout k=%0d got %0d want %0d", k, dout, k);
        else n_pass++;
        n_chk++;
        if (level !== 4'd1) $display("FAIL stream_level k=%0d got %0d want 1", k, level);
        else n_pass++;
      end
    end
    in_en = 0;
  endtask

  task automatic test_overflow();
    test_reset();
    out_ready = 0; in_en = 1;
    for (int k = 1; k <= 81; k++) begin
      din = 16'(k);
      tick();
      if (k == 73) begin
        n_chk++; if (level !== 4'd8) $display("FAIL ovf_full_level got %0d want 8", level); else n_pass++;
        n_chk++; if (out_valid !== 1'b1) $display("FAIL ovf_full_valid got %0b want 1", out_valid); else n_pass++;
      end
      if (k == 80) begin
        n_chk++; if (overflow !== 1'b0) $display("FAIL ovf_early got %0b want 0", overflow); else n_pass++;
      end
    end
    n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_set got %0b want 1", overflow); else n_pass++;
    n_chk++; if (level !== 4'd8) $display("FAIL ovf_drop_level got %0d want 8", level); else n_pass++;
    in_en = 0; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (dout !== 16'(17 + 8 * i) || out_valid !== 1'b1)
        $display("FAIL ovf_drain i=%0d got %0d/%0b want %0d/1", i, dout, out_valid, 17 + 8 * i);
      else n_pass++;
      tick();
    end
    n_chk++; if (out_valid !== 1'b0) $display("FAIL ovf_empty got %0b want 0", out_valid); else n_pass++;
    n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %0b want 1", overflow); else n_pass++;
    ovf_clr = 1; tick(); ovf_clr = 0;
    n_chk++; if (overflow !== 1'b0) $display("FAIL ovf_clr got %0b want 0", overflow); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    logic is_push;
    test_reset();
    out_ready = 0; in_en = 1;
    for (int k = 1; k <= 73; k++) begin
      din = 16'(k);
      tick();
    end
    for (int k = 74; k <= 265; k++) begin
      is_push = (((k - 17) % 8) == 0);
      din = 16'(k);
      out_ready = is_push;
      if (is_push) begin
        n_chk++;
        if (dout !== 16'(k - 64)) $display("FAIL fpp_head k=%0d got %0d want %0d", k, dout, k - 64);
        else n_pass++;
      end
      tick();
      if (is_push) begin
        n_chk++;
        if (level !== 4'd8 || overflow !== 1'b0)
          $display("FAIL fpp_level k=%0d got %0d/%0b want 8/0", k, level, overflow);
        else n_pass++;
      end
    end
    in_en = 0; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (dout !== 16'(209 + 8 * i)) $display("FAIL fpp_drain i=%0d got %0d want %0d", i, dout, 209 + 8 * i);
      else n_pass++;
      tick();
    end
    n_chk++; if (out_valid !== 1'b0) $display("FAIL fpp_empty got %0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_gapped();
    logic exp_v;
    int   j;
    test_reset();
    out_ready2 = 1;
    j = 0;
    for (int c = 0; c < 48; c++) begin
      in_en2 = ((c % 3) == 0);
      if (in_en2) begin
        j++;
        din2 = 16'(-j);
      end else begin
        din2 = 16'h5A5A;
      end
      tick();
      exp_v = in_en2 && ((j % 4) == 0);
      n_chk++;
      if (out_valid2 !== exp_v) $display("FAIL gap_valid c=%0d got %0b want %0b", c, out_valid2, exp_v);
      else n_pass++;
      if (exp_v) begin
        n_chk++;
        if (dout2 !== 16'(-j)) $display("FAIL gap_dout c=%0d got %0d want %0d", c, dout2, -j);
        else n_pass++;
      end
    end
    in_en2 = 0;
  endtask

  task automatic test_async_reset();
    logic exp_v;
    test_reset();
    out_ready = 0; in_en = 1;
    for (int k = 1; k <= 49; k++) begin
      din = 16'(k);
      tick();
    end
    in_en = 0;
    n_chk++; if (level !== 4'd5) $display("FAIL ar_level_pre got %0d want 5", level); else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || dout !== 16'sd0 || level !== 4'd0 || overflow !== 1'b0)
      $display("FAIL ar_outputs got v=%0b d=%0d l=%0d o=%0b want 0", out_valid, dout, level, overflow);
    else n_pass++;
    #2 rst_n = 1'b1;
    out_ready = 1; in_en = 1;
    for (int k = 1; k <= 17; k++) begin
      din = 16'(k);
      tick();
      exp_v = (k == 17);
      n_chk++;
      if (out_valid !== exp_v) $display("FAIL ar_rewarm k=%0d got %0b want %0b", k, out_valid, exp_v);
      else n_pass++;
    end
    n_chk++; if (dout !== 16'sd17) $display("FAIL ar_first got %0d want 17", dout); else n_pass++;
    in_en = 0;
  endtask

  task automatic test_clr_vs_drop();
    test_reset();
    out_ready = 0; in_en = 1;
    for (int k = 1; k <= 80; k++) begin
      din = 16'(k);
      tick();
    end
    din = 16'sd81; ovf_clr = 1;
    tick();
    n_chk++; if (overflow !== 1'b1) $display("FAIL clr_drop got %0b want 1", overflow); else n_pass++;
    din = 16'sd82;
    tick();
    n_chk++; if (overflow !== 1'b0) $display("FAIL clr_after got %0b want 0", overflow); else n_pass++;
    ovf_clr = 0; in_en = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_overflow();
    test_full_push_pop();
    test_gapped();
    test_async_reset();
    test_clr_vs_drop();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fir_decim_fifo.md
# fir_decim_fifo

Decimating output buffer placed directly downstream of the 8-tap moving-average FIR filter. Discards the filter's warm-up samples, then keeps one of every DECIM filtered samples. Kept samples go into a small first-word-fall-through FIFO, which a downstream consumer drains through a valid/ready handshake. A sticky flag records any decimated sample dropped because the FIFO was full.

## Interface
- DATA_W, 16: sample width; matches the filter's signed 16-bit y_out
- DECIM, 8: decimation factor, 1..256; keep one sample in DECIM
- WARMUP, 9: accepted input samples discarded after reset (filter pipeline fill), 0..255
- DEPTH, 8: FIFO entries, power of two, ≥2

- clk  in  1  rising-edge clock, same domain as the filter
- rst_n  in  1  asynchronous active-low reset
- in_en  in  1  din carries a valid filter sample this cycle
- din  in  DATA_W signed  filter output (y_out)
- dout  out  DATA_W signed  FIFO head sample
- out_valid  out  1  dout valid (FIFO not empty)
- out_ready  in  1  consumer accepts dout this cycle
- level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
- overflow  out  1  sticky: a decimated sample was dropped
- ovf_clr  in  1  synchronous clear of overflow

## Operation
- Warm-up counter wcnt:
  - Increments on each in_en while wcnt < WARMUP.
  - These samples are discarded and do not advance the phase counter.
  - Saturates at WARMUP; re-armed only by reset.
- Phase counter phase (0..DECIM-1):
  - Advances on in_en once warm-up is done.
  - push = in_en && warm-up done && phase == DECIM-1; phase then wraps to 0.
  - With DECIM=1, every post-warm-up sample is pushed.
- Pop: pop = out_valid && out_ready.
- FIFO: DEPTH×DATA_W register array with wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus the level counter.
- Push is accepted when level < DEPTH, or when level == DEPTH and pop is high in the same cycle (full with simultaneous pop).
- Push with level == DEPTH and no pop: the sample is dropped, overflow is set, and pointers and level are unchanged. The phase counter still wraps, so decimation alignment is kept.
- Simultaneous accepted push and pop: both pointers advance and level is unchanged.
- Pop with level == 0 cannot occur because out_valid is 0. out_ready is a don't-care while empty.
- Same-cycle overflow set and ovf_clr: set wins.
- Data passes through unmodified. No arithmetic on samples and no sign change.
- Reset (asynchronous, any time, including mid-burst): wcnt, phase, pointers and level go to 0. out_valid=0, dout=0, overflow=0. FIFO contents are discarded and warm-up restarts.

## Timing
- dout and out_valid come from registers only: the head entry and level != 0. There is no combinational path from out_ready or in_en to any output.
- Push-to-visibility latency is 1 cycle. A sample pushed at edge N appears on dout with out_valid=1 after edge N. This applies even when the FIFO was empty (no bypass path).
- A pop at edge N presents the next entry, or out_valid=0, after edge N.
- level updates on the same edge as the push or pop that changes it.
- overflow asserts on the edge that drops the sample. It clears on the edge after ovf_clr is sampled high.
- Throughput: with out_ready held high, one pop per cycle. Sustained input never overflows when the consumer accepts at least one sample per DECIM in_en pulses.

## Test plan
- Defaults, in_en=1 every cycle, din = ramp 1,2,3…, out_ready=1:
  - First 9 samples are discarded.
  - Output sequence is 17, 25, 33, …, one every 8 cycles.
  - Each sample's out_valid rises 1 cycle after its push.
- out_ready=0 throughout:
  - After 8 pushes, level=8 and out_valid=1.
  - The 9th push is dropped and overflow=1.
  - Draining yields exactly the first 8 kept samples in order; overflow stays 1.
  - Pulsing ovf_clr for 1 cycle clears overflow.
- Full FIFO, push and out_ready=1 in the same cycle:
  - Push is accepted and overflow stays 0.
  - level stays 8; the pointers wrap correctly across 3 or more full cycles.
- in_en with gaps (1 of every 3 cycles), DECIM=4, WARMUP=0:
  - Exactly every 4th enabled sample is output.
  - Cycles with in_en=0 do not advance phase.
- rst_n asserted asynchronously mid-operation with level=5:
  - Outputs go to 0 immediately.
  - After release, warm-up restarts: the first kept sample is input number WARMUP+DECIM.
- ovf_clr and a dropping push in the same cycle: overflow=1 after the edge.
